// File: rtl/bcd_stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch and its decade counters.
package stopwatch_pkg;

    // Run/stop/clear controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    // One BCD digit, valid range 0..9.
    typedef logic [3:0] bcd_t;

    localparam bcd_t DIGIT_MAX = 4'd9;

    // Next decade value; anything at or above the maximum returns to zero so a
    // digit can never leave 0..9.
    function automatic bcd_t bcd_next(input bcd_t d);
        return (d >= DIGIT_MAX) ? '0 : bcd_t'(d + 4'd1);
    endfunction

endpackage

// File: rtl/bcd_stopwatch_digit.sv
// Single decade counter: advances when enabled, clears synchronously, and
// raises carry when it is about to roll over from 9 to 0.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic Clock,
    input  logic Reset,
    input  logic clr,
    input  logic en,
    output bcd_t digit,
    output logic carry
);

    bcd_t digit_q;
    bcd_t digit_d;

    // Clear has priority over counting.
    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (en) begin
            digit_d = bcd_next(digit_q);
        end
    end

    // Digit register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;
    assign carry = en && (digit_q == DIGIT_MAX);

endmodule

// File: rtl/bcd_stopwatch.sv
// Four-digit SS.CC stopwatch: button conditioning, centisecond prescaler,
// run/stop/clear controller, cascaded decade counters and lap freeze.
module bcd_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_DIV = 500000
)
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       StartStop,
    input  logic       Clear,
    input  logic       Lap,
    output logic [3:0] D3,
    output logic [3:0] D2,
    output logic [3:0] D1,
    output logic [3:0] D0,
    output logic       Running,
    output logic       Frozen,
    output logic       Wrap
);

    localparam int unsigned   PW        = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    localparam int unsigned BTN_SS  = 0;
    localparam int unsigned BTN_CLR = 1;
    localparam int unsigned BTN_LAP = 2;

    // ------------------------------------------------------------------
    // Button conditioning: two-flop synchronizer plus rising-edge detect
    // ------------------------------------------------------------------
    logic [2:0] btn_meta_q;
    logic [2:0] btn_sync_q;
    logic [2:0] btn_prev_q;
    logic [2:0] btn_pulse;

    // Synchronize the three buttons and remember the previous synchronized level.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            btn_prev_q <= '0;
        end else begin
            btn_meta_q <= {Lap, Clear, StartStop};
            btn_sync_q <= btn_meta_q;
            btn_prev_q <= btn_sync_q;
        end
    end

    assign btn_pulse = btn_sync_q & ~btn_prev_q;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    state_t state_q;
    state_t state_d;

    // Next state; in STOP a simultaneous Clear beats StartStop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (btn_pulse[BTN_SS]) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (btn_pulse[BTN_SS]) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (btn_pulse[BTN_CLR]) begin
                    state_d = IDLE;
                end else if (btn_pulse[BTN_SS]) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick;

    // The tick depends on the current state only, so a tick coinciding with
    // RUN->STOP still lands.
    assign tick = (state_q == RUN) && (presc_q == PRESC_MAX);

    // Count only in RUN, hold in STOP, zero whenever the controller is headed to IDLE.
    always_comb begin
        presc_d = presc_q;
        if (state_d == IDLE) begin
            presc_d = '0;
        end else if (state_q == RUN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // ------------------------------------------------------------------
    // Cascaded decade counters
    // ------------------------------------------------------------------
    logic [4:0]     chain;
    bcd_t [3:0]     live_cnt;
    logic           count_clr;

    assign chain[0]  = tick;
    assign count_clr = (state_d == IDLE);

    for (genvar i = 0; i < 4; i++) begin : g_digit
        bcd_digit u_digit (
            .Clock (Clock),
            .Reset (Reset),
            .clr   (count_clr),
            .en    (chain[i]),
            .digit (live_cnt[i]),
            .carry (chain[i+1])
        );
    end

    logic wrap_q;

    // Carry out of the top digit marks the 99.99 -> 00.00 rollover.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= chain[4];
        end
    end

    // ------------------------------------------------------------------
    // Lap freeze
    // ------------------------------------------------------------------
    logic        frozen_q;
    logic        frozen_d;
    logic [15:0] snap_q;
    logic [15:0] snap_d;

    // Lap toggles only while staying in RUN; leaving RUN or any Clear pulse unfreezes.
    // The snapshot captures the pre-edge live count on the 0->1 toggle.
    always_comb begin
        frozen_d = frozen_q;
        snap_d   = snap_q;
        if ((state_d != RUN) || btn_pulse[BTN_CLR]) begin
            frozen_d = 1'b0;
        end else if ((state_q == RUN) && btn_pulse[BTN_LAP]) begin
            frozen_d = ~frozen_q;
        end
        if (!frozen_q && frozen_d) begin
            snap_d = live_cnt;
        end
    end

    // Freeze flag and snapshot registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            frozen_q <= 1'b0;
            snap_q   <= '0;
        end else begin
            frozen_q <= frozen_d;
            snap_q   <= snap_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: driven only from registers
    // ------------------------------------------------------------------
    assign {D3, D2, D1, D0} = frozen_q ? snap_q : live_cnt;
    assign Running          = (state_q == RUN);
    assign Frozen           = frozen_q;
    assign Wrap             = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Scoreboard bench for bcd_stopwatch with CLK_DIV = 4.
module tb_bcd_stopwatch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ss  = 1'b0;
    logic       clr = 1'b0;
    logic       lap = 1'b0;
    logic [3:0] d3, d2, d1, d0;
    logic       run, frz, wrp;

    bcd_stopwatch #(.CLK_DIV(4)) dut (
        .Clock     (clk),
        .Reset     (rst),
        .StartStop (ss),
        .Clear     (clr),
        .Lap       (lap),
        .D3        (d3),
        .D2        (d2),
        .D1        (d1),
        .D0        (d0),
        .Running   (run),
        .Frozen    (frz),
        .Wrap      (wrp)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [18:0] v;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [18:0] got;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned m     = 0;   // posedges since the most recent entry into RUN

    function automatic logic [15:0] to_bcd(input int unsigned n);
        logic [15:0] r;
        r[15:12] = 4'((n / 1000) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[3:0]   = 4'(n % 10);
        return r;
    endfunction

    function automatic logic [18:0] obs();
        return {run, frz, wrp, d3, d2, d1, d0};
    endfunction

    task automatic push(input string nm, input bit r, input bit f, input bit w,
                        input int unsigned cnt);
        exp_t x;
        x.name = nm;
        x.v    = {r, f, w, to_bcd(cnt)};
        sb.push_back(x);
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
        m += n;
    endtask

    task automatic go_to(input int unsigned target);
        step(target - m);
    endtask

    task automatic start_run();
        ss = 1'b1; step(2); ss = 1'b0; step(1);
        m = 0;
    endtask

    task automatic stop_and_clear();
        ss  = 1'b1; step(2); ss  = 1'b0; step(1);
        clr = 1'b1; step(2); clr = 1'b0; step(3);
    endtask

    task automatic test_reset();
        rst = 1'b1; step(3); rst = 1'b0;
        push("reset_idle", 0, 0, 0, 0);
        step(20);
        e = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== e.v) begin n_err++; $display("FAIL %s: got RFW=%b D=%h, want RFW=%b D=%h", e.name, got[18:16], got[15:0], e.v[18:16], e.v[15:0]); end
        push("clear_in_idle", 0, 0, 0, 0);
        clr = 1'b1; step(2); clr = 1'b0; step(5);
        e = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== e.v) begin n_err++; $display("FAIL %s: got RFW=%b D=%h, want RFW=%b D=%h", e.name, got[18:16], got[15:0], e.v[18:16], e.v[15:0]); end
    endtask

    task automatic test_start();
        ss = 1'b1;
        push("start_not_before_3rd_edge", 0, 0, 0, 0);
        step(2);
        e = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== e.v) begin n_err++; $display("FAIL %s: got RFW=%b D=%h, want RFW=%b D=%h", e.name, got[18:16], got[15:0], e.v[18:16], e.v[15:0]); end
        push("start_after_3rd_edge", 1, 0, 0, 0);
        step(1); m = 0;
        e = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== e.v) begin n_err++; $display("FAIL %s: got RFW=%b D=%h, want RFW=%b D=%h", e.name, got[18:16], got[15:0], e.v[18:16], e.v[15:0]); end
        push("held_button_single_toggle", 1, 0, 0, 1);
        go_to(7); ss = 1'b0;
        e = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== e.v) begin n_err++; $display("FAIL %s: got RFW=%b D=%h, want RFW=%b D=%h", e.name, got[18:16], got[15:0], e.v[18:16], e.v[15:0]); end
        push("count_after_40", 1, 0, 0, 10);
        go_to(40);
        e = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== e.v) begin n_err++; $display("FAIL %s: got RFW=%b D=%h, want RFW=%b D=%h", e.name, got[18:16], got[15:0], e.v[18:16], e.v[15:0]); end
    endtask

    task automatic test_stop_clear();
        push("clear_ignored_in_run", 1, 0, 0, 25);
        clr = 1'b1; step(2); clr = 1'b0;
        go_to(100);
        e = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== e.v) begin n_err++; $display("FAIL %s: got RFW=%b D=%h, want RFW=%b D=%h", e.name, got[18:16], got[15:0], e.v[18:16], e.v[15:0]); end
        go_to(598);
        push("stop_at_0150", 0, 0, 0, 150);
        ss = 1'b1; step(2); ss = 1'b0; step(1);
        e = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== e.v) begin n_err++; $display("FAIL %s: got RFW=%b D=%h, want RFW=%b D=%h", e.name, got[18:16], got[15:0], e.v[18:16], e.v[15:0]); end
        push("hold_in_stop", 0, 0, 0, 150);
        step(100);
        e = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== e.v) begin n_err++; $display("FAIL %s: got RFW=%b D=%h, want RFW=%b D=%h", e.name, got[18:16], got[15:0], e.v[18:16], e.v[15:0]); end
        push("clear_from_stop", 0, 0, 0, 0);
        clr = 1'b1; step(2); clr = 1'b0; step(1);
        e = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== e.v) begin n_err++; $display("FAIL %s: got RFW=%b D=%h, want RFW=%b D=%h", e.name, got[18:16], got[15:0], e.v[18:16], e.v[15:0]); end
    endtask

    task automatic test_simultaneous();
        start_run();
        go_to(9);
        // Stop edge lands on m = 12, which is also a tick edge.
        push("run_ss_and_clear_stops", 0, 0, 0, 3);
        ss = 1'b1; clr = 1'b1; step(2); ss = 1'b0; clr = 1'b0; step(1);
        e = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== e.v) begin n_err++; $display("FAIL %s: got RFW=%b D=%h, want RFW=%b D=%h", e.name, got[18:16], got[15:0], e.v[18:16], e.v[15:0]); end
        push("lap_ignored_in_stop", 0, 0, 0, 3);
        lap = 1'b1; step(2); lap = 1'b0; step(3);
        e = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== e.v) begin n_err++; $display("FAIL %s: got RFW=%b D=%h, want RFW=%b D=%h", e.name, got[18:16], got[15:0], e.v[18:16], e.v[15:0]); end
        push("stop_ss_and_clear_idles", 0, 0, 0, 0);
        ss = 1'b1; clr = 1'b1; step(2); ss = 1'b0; clr = 1'b0; step(1);
        e = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== e.v) begin n_err++; $display("FAIL %s: got RFW=%b D=%h, want RFW=%b D=%h", e.name, got[18:16], got[15:0], e.v[18:16], e.v[15:0]); end
    endtask

    task automatic test_wrap();
        start_run();
        push("at_9999", 1, 0, 0, 9999);
        go_to(39999);
        e = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== e.v) begin n_err++; $display("FAIL %s: got RFW=%b D=%h, want RFW=%b D=%h", e.name, got[18:16], got[15:0], e.v[18:16], e.v[15:0]); end
        push("wrap_pulse", 1, 0, 1, 0);
        step(1);
        e = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== e.v) begin n_err++; $display("FAIL %s: got RFW=%b D=%h, want RFW=%b D=%h", e.name, got[18:16], got[15:0], e.v[18:16], e.v[15:0]); end
        push("wrap_single_cycle", 1, 0, 0, 0);
        step(1);
        e = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== e.v) begin n_err++; $display("FAIL %s: got RFW=%b D=%h, want RFW=%b D=%h", e.name, got[18:16], got[15:0], e.v[18:16], e.v[15:0]); end
        stop_and_clear();
    endtask

    task automatic test_lap();
        start_run();
        go_to(166);
        push("lap_freeze_0042", 1, 1, 0, 42);
        lap = 1'b1; step(2); lap = 1'b0; step(1);
        e = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== e.v) begin n_err++; $display("FAIL %s: got RFW=%b D=%h, want RFW=%b D=%h", e.name, got[18:16], got[15:0], e.v[18:16], e.v[15:0]); end
        push("frozen_holds_0042", 1, 1, 0, 42);
        go_to(200);
        e = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== e.v) begin n_err++; $display("FAIL %s: got RFW=%b D=%h, want RFW=%b D=%h", e.name, got[18:16], got[15:0], e.v[18:16], e.v[15:0]); end
        go_to(226);
        push("unfreeze_live_0057", 1, 0, 0, 57);
        lap = 1'b1; step(2); lap = 1'b0; step(1);
        e = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== e.v) begin n_err++; $display("FAIL %s: got RFW=%b D=%h, want RFW=%b D=%h", e.name, got[18:16], got[15:0], e.v[18:16], e.v[15:0]); end
        go_to(240);
        push("refreeze_0060", 1, 1, 0, 60);
        lap = 1'b1; step(2); lap = 1'b0; step(1);
        e = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== e.v) begin n_err++; $display("FAIL %s: got RFW=%b D=%h, want RFW=%b D=%h", e.name, got[18:16], got[15:0], e.v[18:16], e.v[15:0]); end
        go_to(250);
        push("stop_unfreezes", 0, 0, 0, 63);
        ss = 1'b1; step(2); ss = 1'b0; step(1);
        e = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== e.v) begin n_err++; $display("FAIL %s: got RFW=%b D=%h, want RFW=%b D=%h", e.name, got[18:16], got[15:0], e.v[18:16], e.v[15:0]); end
        clr = 1'b1; step(2); clr = 1'b0; step(3);
    endtask

    task automatic test_async_reset();
        start_run();
        go_to(1330);
        push("frozen_at_0333", 1, 1, 0, 333);
        lap = 1'b1; step(2); lap = 1'b0; step(1);
        e = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== e.v) begin n_err++; $display("FAIL %s: got RFW=%b D=%h, want RFW=%b D=%h", e.name, got[18:16], got[15:0], e.v[18:16], e.v[15:0]); end
        push("async_reset_mid_cycle", 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        e = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== e.v) begin n_err++; $display("FAIL %s: got RFW=%b D=%h, want RFW=%b D=%h", e.name, got[18:16], got[15:0], e.v[18:16], e.v[15:0]); end
        @(negedge clk);
        step(2); rst = 1'b0;
        step(2);
        push("post_reset_not_yet", 0, 0, 0, 0);
        ss = 1'b1; step(2);
        e = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== e.v) begin n_err++; $display("FAIL %s: got RFW=%b D=%h, want RFW=%b D=%h", e.name, got[18:16], got[15:0], e.v[18:16], e.v[15:0]); end
        push("post_reset_start", 1, 0, 0, 0);
        ss = 1'b0; step(1); m = 0;
        e = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== e.v) begin n_err++; $display("FAIL %s: got RFW=%b D=%h, want RFW=%b D=%h", e.name, got[18:16], got[15:0], e.v[18:16], e.v[15:0]); end
        push("post_reset_first_tick", 1, 0, 0, 1);
        go_to(4);
        e = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== e.v) begin n_err++; $display("FAIL %s: got RFW=%b D=%h, want RFW=%b D=%h", e.name, got[18:16], got[15:0], e.v[18:16], e.v[15:0]); end
        stop_and_clear();
    endtask

    initial begin
        test_reset();
        test_start();
        test_stop_clear();
        test_simultaneous();
        test_lap();
        test_async_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
